btc_result_drain: RTL and testbench

- Return-path counterpart of the four-core round-robin BTC dispatcher.
- Captures the 512-bit result word that the BTC top emits a fixed number of cycles after each dispatch, and tags it with the originating core slot.
- Buffers results in a small FIFO and serialises each one into 128-bit beats on a valid/ready stream toward the output buffer/SRAM writer.
- Sits between the BTC top result port and the memory write path.

---
 rtl/btc_pkg.sv | 27 ++
 rtl/btc_drain_fifo.sv | 48 ++++
 rtl/btc_result_drain.sv | 74 +++++++
 tb/tb_btc_result_drain.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btc_pkg.sv
// Shared constants and types for the BTC result return path: word/beat geometry,
// core-slot tag type and the tagged FIFO entry.
package btc_pkg;

  localparam int DATA_W    = 512;
  localparam int OUT_W     = 128;
  localparam int NUM_CORES = 4;
  localparam int RES_LAT   = 2;
  localparam int DEPTH     = 4;

  localparam int BEATS  = DATA_W / OUT_W;
  localparam int SLOT_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef struct packed {
    slot_t             slot;
    logic [DATA_W-1:0] data;
  } result_entry_t;

  typedef struct packed {
    logic  vld;
    slot_t slot;
  } tag_t;

endpackage

// File: rtl/btc_drain_fifo.sv
// First-word-fall-through FIFO of tagged BTC results. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module btc_drain_fifo
  import btc_pkg::*;
#(
  parameter int FIFO_DEPTH = DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  result_entry_t                 din_i,
  input  logic                          pop_i,
  output result_entry_t                 head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]   wr_q, rd_q;
  result_entry_t mem_q [FIFO_DEPTH];
  logic          wr_en, rd_en;

  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/btc_result_drain.sv
// Captures BTC result words RES_LAT cycles after dispatch, tags them with the
// round-robin core slot, buffers them and streams each out as OUT_W-bit beats.
module btc_result_drain
  import btc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_valid,
  input  logic [DATA_W-1:0]         result_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [SLOT_W-1:0]         out_core_id,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow
);

  slot_t             slot_q;
  tag_t              tag_q [RES_LAT];
  logic [BEAT_W-1:0] beat_q;
  logic              overflow_q;

  tag_t              cap;
  result_entry_t     head;
  result_entry_t     din;
  logic              full, empty;
  logic              xfer, pop;

  assign cap  = tag_q[RES_LAT-1];
  assign din  = '{slot: cap.slot, data: result_in};

  // Stream handshake: a beat moves on any edge with out_valid && out_ready;
  // while stalled the beat, its tag and out_last are held, and out_valid
  // cannot fall until that beat has been taken.
  assign xfer = out_valid && out_ready;
  assign pop  = xfer && out_last;

  btc_drain_fifo #(.FIFO_DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap.vld),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign out_valid   = !empty;
  assign out_last    = (beat_q == BEAT_W'(BEATS - 1));
  assign out_data    = empty ? '0 : head.data[beat_q*OUT_W +: OUT_W];
  assign out_core_id = empty ? '0 : head.slot;
  assign overflow    = overflow_q;

  // Slot counter leaves reset on the same edge as the dispatcher's, so the tag
  // shifted down the pipeline names the core whose word arrives RES_LAT later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < RES_LAT; i++) tag_q[i] <= '0;
    end else begin
      slot_q   <= slot_q + slot_t'(1);
      tag_q[0] <= '{vld: dispatch_valid, slot: slot_q};
      for (int i = 1; i < RES_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (xfer) beat_q <= out_last ? '0 : beat_q + BEAT_W'(1);
      if (cap.vld && full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_btc_result_drain.sv
// Directed bench for btc_result_drain with a negedge scoreboard model of the
// slot counter, tag delay, FIFO occupancy, beat order and sticky overflow.
module tb_btc_result_drain;
  import btc_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst;
  logic                 dispatch_valid;
  logic [DATA_W-1:0]    result_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [SLOT_W-1:0]    out_core_id;
  logic                 out_last;
  logic [LVL_W-1:0]     fifo_level;
  logic                 overflow;

  btc_result_drain dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_valid (dispatch_valid),
    .result_in      (result_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_core_id    (out_core_id),
    .out_last       (out_last),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: {slot, word} of every word the model accepts
  logic [SLOT_W+DATA_W-1:0] exp_q[$];
  logic [SLOT_W+DATA_W-1:0] m_head;
  int    m_count, m_beat;
  logic  m_ovf, m_xfer, m_pop, m_valid;
  slot_t m_slot;
  logic  dv_h [2];
  slot_t sl_h [2];

  always @(negedge clk) begin
    if (rst) begin
      m_count = 0; m_beat = 0; m_ovf = 1'b0; m_slot = '0;
      dv_h[0] = 1'b0; dv_h[1] = 1'b0; sl_h[0] = '0; sl_h[1] = '0;
      exp_q.delete();
    end else begin
      m_valid = (m_count != 0);
      chk("out_valid", out_valid, m_valid);
      chk("fifo_level", fifo_level, m_count);
      chk("overflow", overflow, m_ovf);
      m_xfer = m_valid && out_ready;
      m_pop  = m_xfer && (m_beat == BEATS - 1);
      if (m_valid) begin
        m_head = exp_q[0];
        chk("out_data", out_data, m_head[m_beat*OUT_W +: OUT_W]);
        chk("out_core_id", out_core_id, m_head[DATA_W +: SLOT_W]);
        chk("out_last", out_last, m_beat == BEATS - 1);
      end
      if (dv_h[1]) begin
        if (m_count < DEPTH || m_pop) begin
          exp_q.push_back({sl_h[1], result_in});
          m_count++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (m_xfer) begin
        if (m_pop) begin
          void'(exp_q.pop_front());
          m_count--;
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      dv_h[1] = dv_h[0]; sl_h[1] = sl_h[0];
      dv_h[0] = dispatch_valid; sl_h[0] = m_slot;
      m_slot  = m_slot + slot_t'(1);
    end
  end

  // driver: the word for a dispatch appears on result_in two steps later
  logic              v_pipe [2];
  logic [DATA_W-1:0] w_pipe [2];

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic step(input logic dv, input logic [DATA_W-1:0] w);
    dispatch_valid = dv;
    result_in = v_pipe[1] ? w_pipe[1] : rand_word();
    v_pipe[1] = v_pipe[0]; w_pipe[1] = w_pipe[0];
    v_pipe[0] = dv;        w_pipe[0] = w;
    @(posedge clk); #1;
  endtask

  task automatic clear_pipe();
    v_pipe[0] = 1'b0; v_pipe[1] = 1'b0;
    w_pipe[0] = '0;   w_pipe[1] = '0;
    dispatch_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_pipe();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  logic [DATA_W-1:0] w1;
  int guard;

  initial begin
    rst = 1'b1; out_ready = 1'b0; result_in = '0;
    clear_pipe();
    w1 = {128'h4, 128'h3, 128'h2, 128'h1};
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;

    // single word dispatched at slot 1
    out_ready = 1'b1;
    step(1'b0, '0);
    step(1'b1, w1);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("c1_valid_after_capture", out_valid, 1);
    chk("c1_first_beat", out_data, 1);
    chk("c1_core_id", out_core_id, 1);
    repeat (6) step(1'b0, '0);
    chk("c1_level_end", fifo_level, 0);

    // backpressure for 5 cycles after out_valid rises
    do_reset();
    out_ready = 1'b0;
    step(1'b0, '0);
    step(1'b1, w1);
    step(1'b0, '0);
    step(1'b0, '0);
    repeat (5) step(1'b0, '0);
    chk("c2_hold_valid", out_valid, 1);
    chk("c2_hold_beat0", out_data, 1);
    out_ready = 1'b1;
    repeat (6) step(1'b0, '0);
    chk("c2_level_end", fifo_level, 0);

    // overflow from six back-to-back dispatches
    do_reset();
    out_ready = 1'b0;
    repeat (6) step(1'b1, rand_word());
    repeat (3) step(1'b0, '0);
    chk("c3_level_sat", fifo_level, 4);
    chk("c3_overflow", overflow, 1);
    out_ready = 1'b1;
    repeat (20) step(1'b0, '0);
    chk("c3_level_end", fifo_level, 0);

    // full FIFO with capture on the same edge as the head's last beat
    do_reset();
    out_ready = 1'b0;
    repeat (4) step(1'b1, rand_word());
    repeat (2) step(1'b0, '0);
    chk("c4_full", fifo_level, 4);
    out_ready = 1'b1;
    step(1'b0, '0);
    step(1'b1, rand_word());
    step(1'b0, '0);
    step(1'b0, '0);
    chk("c4_level_kept", fifo_level, 4);
    chk("c4_no_overflow", overflow, 0);
    repeat (24) step(1'b0, '0);
    chk("c4_level_end", fifo_level, 0);

    // one dispatch every 4 cycles starting at slot 3
    do_reset();
    out_ready = 1'b1;
    repeat (3) step(1'b0, '0);
    repeat (5) begin
      step(1'b1, rand_word());
      step(1'b0, '0);
      step(1'b0, '0);
      step(1'b0, '0);
      chk("c5_core_id", out_core_id, 3);
    end
    repeat (6) step(1'b0, '0);
    chk("c5_no_overflow", overflow, 0);

    // asynchronous reset while beat 2 of a word is pending
    out_ready = 1'b0;
    repeat (6) step(1'b1, rand_word());
    repeat (2) step(1'b0, '0);
    out_ready = 1'b1;
    guard = 0;
    while (m_beat != 2 && guard < 20) begin
      step(1'b0, '0);
      guard++;
    end
    chk("c6_reach_beat2", guard < 20, 1);
    chk("c6_pre_overflow", overflow, 1);
    #2 rst = 1'b1;
    #1;
    chk("c6_rst_valid", out_valid, 0);
    chk("c6_rst_level", fifo_level, 0);
    chk("c6_rst_overflow", overflow, 0);
    clear_pipe();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, '0);
    step(1'b1, w1);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("c6_restart_beat0", out_data, 1);
    repeat (6) step(1'b0, '0);
    chk("c6_level_end", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
